// File: rtl/fround_arbiter.sv
// Round-robin arbiter sharing one combinational FRound rounder among NUM_REQ FPU units.
// Optional grant/inexact statistics counters are enabled by defining FROUND_ARB_STATS_EN.
module fround_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TAG_W   = 5
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic [2:0]               frm_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0]       req_sign_i,
  input  logic [32*NUM_REQ-1:0]    req_sig_i,
  input  logic [8*NUM_REQ-1:0]     req_exp_i,
  input  logic [3*NUM_REQ-1:0]     req_rm_i,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag_i,
  output logic                     rnd_sign_o,
  output logic [31:0]              rnd_sig_o,
  output logic [7:0]               rnd_exp_o,
  output logic [2:0]               rnd_rm_o,
  input  logic [22:0]              rnd_sig_i,
  input  logic [7:0]               rnd_exp_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic                     res_sign_o,
  output logic [22:0]              res_sig_o,
  output logic [7:0]               res_exp_o,
  output logic [TAG_W-1:0]         res_tag_o,
  output logic [4:0]               res_flags_o,
  output logic                     res_illegal_o
`ifdef FROUND_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]    stat_grants_o,
  output logic [15:0]              stat_inexact_o
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic               accept;
  logic [2:0]         rm_sel;
  logic [2:0]         rm_res;
  logic               illegal;
  logic [TAG_W-1:0]   tag_sel;
  logic [4:0]         flags_d;

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    logic [PTR_W:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!grant_any && req_valid_i[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
    grant = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_any && (PTR_W'(k) == grant_idx)) grant[k] = 1'b1;
    end
  end

  // Field mux; grant_idx stays 0 with no grant, so requester 0 is presented.
  always_comb begin
    rnd_sign_o = req_sign_i[0];
    rnd_sig_o  = req_sig_i[31:0];
    rnd_exp_o  = req_exp_i[7:0];
    rm_sel     = req_rm_i[2:0];
    tag_sel    = req_tag_i[TAG_W-1:0];
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == grant_idx) begin
        rnd_sign_o = req_sign_i[k];
        rnd_sig_o  = req_sig_i[32*k +: 32];
        rnd_exp_o  = req_exp_i[8*k +: 8];
        rm_sel     = req_rm_i[3*k +: 3];
        tag_sel    = req_tag_i[TAG_W*k +: TAG_W];
      end
    end
  end

  // Dynamic rm resolution; reserved encodings trap and fall back to RTZ.
  always_comb begin
    rm_res   = (rm_sel == 3'b111) ? frm_i : rm_sel;
    illegal  = (rm_res >= 3'b101);
    rnd_rm_o = illegal ? 3'b001 : rm_res;
  end

  always_comb begin
    accept      = grant_any && (!res_valid_o || res_ready_i) && !flush_i;
    req_ready_o = accept ? grant : '0;
    ptr_next    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    flags_d     = illegal ? 5'b0
                          : {2'b00, (rnd_exp_i == 8'hFF), 1'b0, (|rnd_sig_o[7:0])};
  end

  // One-entry output register and round-robin pointer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      res_valid_o   <= 1'b0;
      res_sign_o    <= 1'b0;
      res_sig_o     <= '0;
      res_exp_o     <= '0;
      res_tag_o     <= '0;
      res_flags_o   <= '0;
      res_illegal_o <= 1'b0;
      ptr           <= '0;
    end else if (flush_i) begin
      res_valid_o <= 1'b0;
      ptr         <= '0;
    end else if (accept) begin
      res_valid_o   <= 1'b1;
      res_sign_o    <= rnd_sign_o;
      res_sig_o     <= rnd_sig_i;
      res_exp_o     <= rnd_exp_i;
      res_tag_o     <= tag_sel;
      res_flags_o   <= flags_d;
      res_illegal_o <= illegal;
      ptr           <= ptr_next;
    end else if (res_valid_o && res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

`ifdef FROUND_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];
  logic [15:0] inexact_cnt;

  // Saturating per-requester grant and inexact counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) grant_cnt[k] <= '0;
      inexact_cnt <= '0;
    end else if (flush_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) grant_cnt[k] <= '0;
      inexact_cnt <= '0;
    end else if (accept) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (grant[k] && (grant_cnt[k] != 16'hFFFF)) grant_cnt[k] <= grant_cnt[k] + 16'd1;
      end
      if (flags_d[0] && (inexact_cnt != 16'hFFFF)) inexact_cnt <= inexact_cnt + 16'd1;
    end
  end

  always_comb begin
    stat_grants_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) stat_grants_o[16*k +: 16] = grant_cnt[k];
    stat_inexact_o = inexact_cnt;
  end
`endif

endmodule
